// File: rtl/varredura_linhas.sv
// Row-scan sequencer for a 5x7 LED matrix: active-low one-hot row drive, per-row dwell, blanking gap, end-of-frame pulse.
// Latency: every output is registered and responds one clock after the edge that samples enable.
// Backpressure: none; enable=0 parks the scan in OCIOSO and holds the current row index.
module varredura_linhas #(
  parameter int NUM_LINHAS    = 7,
  parameter int TEMPO_LINHA   = 4,
  parameter int TEMPO_APAGADO = 2,
  parameter int LARG_TEMPO    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [2:0]            contador,
  output logic [NUM_LINHAS-1:0] linhas,
  output logic                  fim_quadro,
  output logic                  ativo
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ACESO   = 2'd1;
  localparam logic [1:0] APAGADO = 2'd2;

  localparam logic [2:0] ULTIMA = 3'(NUM_LINHAS - 1);
  localparam logic [LARG_TEMPO-1:0] FIM_ACESO   = LARG_TEMPO'(TEMPO_LINHA - 1);
  localparam logic [LARG_TEMPO-1:0] FIM_APAGADO =
    LARG_TEMPO'((TEMPO_APAGADO > 0) ? TEMPO_APAGADO - 1 : 0);

  logic [1:0]            estado;
  logic [LARG_TEMPO-1:0] tempo;
  logic [2:0]            proxima;
  logic                  vira;

  // Active-low one-hot pattern lighting a single row.
  function automatic logic [NUM_LINHAS-1:0] linha_acesa(input logic [2:0] idx);
    return ~(NUM_LINHAS'(1) << idx);
  endfunction

  // Next row index with wrap at the last row; the wrap flags end of frame.
  always_comb begin
    vira    = (contador == ULTIMA);
    proxima = vira ? 3'd0 : contador + 3'd1;
  end

  // Scan FSM: dwell on a lit row, blank, advance; disabling parks without advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      tempo      <= '0;
      contador   <= 3'd0;
      linhas     <= '1;
      fim_quadro <= 1'b0;
      ativo      <= 1'b0;
    end else begin
      fim_quadro <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (enable) begin
            // Resume relights the held row with a full dwell, no blank first.
            estado <= ACESO;
            tempo  <= '0;
            linhas <= linha_acesa(contador);
            ativo  <= 1'b1;
          end
        end
        ACESO: begin
          if (!enable) begin
            estado <= OCIOSO;
            tempo  <= '0;
            linhas <= '1;
            ativo  <= 1'b0;
          end else if (tempo == FIM_ACESO) begin
            tempo <= '0;
            if (TEMPO_APAGADO > 0) begin
              estado <= APAGADO;
              linhas <= '1;
            end else begin
              contador   <= proxima;
              linhas     <= linha_acesa(proxima);
              fim_quadro <= vira;
            end
          end else begin
            tempo <= tempo + 1'b1;
          end
        end
        APAGADO: begin
          if (!enable) begin
            estado <= OCIOSO;
            tempo  <= '0;
            linhas <= '1;
            ativo  <= 1'b0;
          end else if (tempo == FIM_APAGADO) begin
            // Row index and row drive move together so the decoders never light a stale pattern.
            estado     <= ACESO;
            tempo      <= '0;
            contador   <= proxima;
            linhas     <= linha_acesa(proxima);
            fim_quadro <= vira;
          end else begin
            tempo <= tempo + 1'b1;
          end
        end
        default: begin
          estado <= OCIOSO;
          tempo  <= '0;
          linhas <= '1;
          ativo  <= 1'b0;
        end
      endcase
    end
  end

endmodule
